// File: rtl/apb_ucpd_pkg.sv
// apb_ucpd_pkg: shared UCPD transmit constants, 4b5b table and CRC symbol-image helper.
package apb_ucpd_pkg;
  localparam int PRE_BIT_NUM = 64;
  localparam int SOP_BIT_NUM = 20;
  localparam int CRC_BIT_NUM = 40;
  localparam int TX_BIT5_NUM = 5;
  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_RST1 = 5'b00111;
  localparam logic [4:0] K_RST2 = 5'b11001;
  localparam logic [4:0] K_EOP = 5'b01101;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB88320;
  localparam logic [31:0] CRC_SEED = 32'hFFFFFFFF;
  // code for nibble n sits at [5n+4:5n]; bit 0 of each code goes on the wire first
  localparam logic [79:0] ENC_TBL = {5'b11101, 5'b11100, 5'b11011, 5'b11010,
                                     5'b10111, 5'b10110, 5'b10011, 5'b10010,
                                     5'b01111, 5'b01110, 5'b01011, 5'b01010,
                                     5'b10101, 5'b10100, 5'b01001, 5'b11110};
  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    return ENC_TBL[int'(n) * 5 +: 5];
  endfunction
  function automatic logic [CRC_BIT_NUM-1:0] crc_img(input logic [31:0] c);
    logic [CRC_BIT_NUM-1:0] r;
    for (int i = 0; i < 8; i++) r[5*i +: 5] = enc4b5b(c[4*i +: 4]);
    return r;
  endfunction
endpackage

// File: rtl/apb_ucpd_crc32.sv
// apb_ucpd_crc32: byte-parallel bit-reflected CRC32 with synchronous init and update.
module apb_ucpd_crc32
  import apb_ucpd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        upd_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] crc_q, crc_d, nxt;
  always_comb begin
    nxt = crc_q;
    for (int i = 0; i < 8; i++) nxt = {1'b0, nxt[31:1]} ^ ((nxt[0] ^ data_i[i]) ? CRC_POLY_REF : 32'h0);
    crc_d = init_i ? CRC_SEED : upd_i ? nxt : crc_q;
  end
  always_ff @(posedge clk) crc_q <= rst ? CRC_SEED : crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/apb_ucpd_tx_enc.sv
// apb_ucpd_tx_enc: UCPD 4b5b transmit encoder, LSB-first serialiser and BMC line driver.
// Define UCPD_TX_CRC_EN to use the internal CRC32 instead of the external tx_crc.
module apb_ucpd_tx_enc
  import apb_ucpd_pkg::*;
(
  input  logic        ic_clk,
  input  logic        ic_rst,
  input  logic        ucpden,
  input  logic        bit_clk_red,
  input  logic        hbit_clk_red,
  input  logic        pre_en,
  input  logic        sop_en,
  input  logic        data_en,
  input  logic        crc_en,
  input  logic        eop_en,
  input  logic        wait_en,
  input  logic        tx_pre_cmplt,
  input  logic        tx_data_cmplt,
  input  logic        tx_crc_cmplt,
  input  logic        tx_bit5_cmplt,
  input  logic        txfifo_ld_en,
  input  logic [7:0]  txdr,
  input  logic [19:0] tx_ordset,
  input  logic [31:0] tx_crc,
  output logic        tx_bit,
  output logic        cc_out,
  output logic [31:0] crc_val
);
  localparam int SR_W = CRC_BIT_NUM;
  localparam int CNT_W = $clog2(PRE_BIT_NUM);
  logic rst, active, shift, pre_rise, ld_eop, ld_crc, ld_ord;
  logic pre_q, tx_bit_q, tx_bit_d, cc_q, cc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [31:0] crc_src;
  assign rst = ic_rst | ~ucpden;
  assign shift = sop_en | data_en | crc_en | eop_en;
  assign active = pre_en | shift;
  assign pre_rise = pre_en & ~pre_q;
  assign ld_eop = tx_crc_cmplt | (tx_bit5_cmplt & (data_en | crc_en));
  assign ld_crc = data_en & tx_data_cmplt & ~tx_bit5_cmplt;
  assign ld_ord = pre_en & tx_pre_cmplt;
`ifdef UCPD_TX_CRC_EN
  logic unused_crc;
  assign unused_crc = ^tx_crc;
  apb_ucpd_crc32 u_crc (
    .clk(ic_clk),
    .rst(rst),
    .init_i(pre_rise),
    .upd_i(txfifo_ld_en & (sop_en | data_en)),
    .data_i(txdr),
    .crc_o(crc_val)
  );
  assign crc_src = ~crc_val;
`else
  assign crc_val = CRC_SEED;
  assign crc_src = tx_crc;
`endif
  // a load replaces the shift so the next phase starts on the same bit boundary
  always_comb begin
    sr_d = ld_eop ? SR_W'(K_EOP)
         : ld_crc ? crc_img(crc_src)
         : txfifo_ld_en ? SR_W'({enc4b5b(txdr[7:4]), enc4b5b(txdr[3:0])})
         : ld_ord ? SR_W'(tx_ordset)
         : (bit_clk_red & shift) ? {1'b0, sr_q[SR_W-1:1]} : sr_q;
    cnt_d = pre_rise ? '0 : (pre_en & bit_clk_red) ? cnt_q + 1'b1 : cnt_q;
    tx_bit_d = (pre_en & ~tx_pre_cmplt) ? cnt_d[0] : sr_d[0];
    cc_d = wait_en ? cc_q & ~hbit_clk_red
         : active ? cc_q ^ (pre_rise | bit_clk_red) ^ (hbit_clk_red & tx_bit_q) : 1'b0;
  end
  always_ff @(posedge ic_clk) begin
    if (rst) begin
      pre_q <= 1'b0;
      cnt_q <= '0;
      sr_q <= '0;
      tx_bit_q <= 1'b0;
      cc_q <= 1'b0;
    end else begin
      pre_q <= pre_en;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      tx_bit_q <= tx_bit_d;
      cc_q <= cc_d;
    end
  end
  assign tx_bit = tx_bit_q;
  assign cc_out = cc_q;
endmodule
